// File: rtl/lidar_pkg.sv
// Shared constants, command encoding and tx-state codes for the LiDAR scan responder.
// The GET_HEALTH path is built only when LIDAR_HEALTH_EN is defined.
package lidar_pkg;

  localparam logic [7:0] SyncByte         = 8'hA5;
  localparam logic [7:0] SyncByte2        = 8'h5A;
  localparam logic [7:0] CmdScanByte      = 8'h60;
  localparam logic [7:0] CmdForceScanByte = 8'h61;
  localparam logic [7:0] CmdStopByte      = 8'h65;
  localparam logic [7:0] CmdResetByte     = 8'h80;
  localparam logic [7:0] CmdHealthByte    = 8'h52;
  localparam logic [7:0] AnsTypeMeas      = 8'h81;

  localparam int unsigned ScanDescLen = 7;
  localparam int unsigned PktLen      = 5;
  localparam int unsigned HealthLen   = 10;

  // Byte 0 is the most significant byte of each constant.
  localparam logic [55:0] ScanDesc = {SyncByte, SyncByte2, 8'h05, 8'h00, 8'h00, 8'h40,
                                      AnsTypeMeas};
  localparam logic [79:0] HealthResp = {SyncByte, SyncByte2, 8'h03, 8'h00, 8'h00, 8'h00,
                                        8'h06, 8'h00, 8'h00, 8'h00};

  localparam logic [3:0] StIdle       = 4'd0;
  localparam logic [3:0] StDescLoad   = 4'd1;
  localparam logic [3:0] StDescWait   = 4'd2;
  localparam logic [3:0] StSampleWait = 4'd3;
  localparam logic [3:0] StPktLoad    = 4'd4;
  localparam logic [3:0] StPktWait    = 4'd5;
  localparam logic [3:0] StHealthLoad = 4'd6;
  localparam logic [3:0] StHealthWait = 4'd7;

  typedef enum logic [2:0] {
    CmdNone,
    CmdStart,
    CmdStop,
    CmdReset,
    CmdHealth
  } cmd_e;

  function automatic logic [7:0] scan_desc_byte(input logic [3:0] idx);
    logic [55:0] sh;
    sh = ScanDesc << {idx, 3'b000};
    return sh[55:48];
  endfunction

  function automatic logic [7:0] health_byte(input logic [3:0] idx);
    logic [79:0] sh;
    sh = HealthResp << {idx, 3'b000};
    return sh[79:72];
  endfunction

endpackage

// File: rtl/lidar_cmd_parser.sv
// Two-byte host command parser: 0xA5 sync, then command byte, with a resync timeout.
// Emits one-cycle command and error strobes; 0x52 decodes only with LIDAR_HEALTH_EN.
module lidar_cmd_parser
  import lidar_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output cmd_e       cmd,
  output logic       cmd_error
);

  localparam int unsigned TmrW = $clog2(SYNC_TIMEOUT_CYCLES + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(SYNC_TIMEOUT_CYCLES - 1);

  localparam logic PsWaitSync = 1'b0;
  localparam logic PsWaitCmd  = 1'b1;

  logic            state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            valid_d, err_d;
  cmd_e            cmd_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cmd_d   = CmdNone;
    if (state_q == PsWaitSync) begin
      if (rx_valid && (rx_data == SyncByte)) begin
        state_d = PsWaitCmd;
        tmr_d   = '0;
      end
    end else if (rx_valid) begin
      tmr_d = '0;
      if (rx_data != SyncByte) begin
        state_d = PsWaitSync;
        case (rx_data)
          CmdScanByte, CmdForceScanByte: begin valid_d = 1'b1; cmd_d = CmdStart; end
          CmdStopByte:                   begin valid_d = 1'b1; cmd_d = CmdStop;  end
          CmdResetByte:                  begin valid_d = 1'b1; cmd_d = CmdReset; end
`ifdef LIDAR_HEALTH_EN
          CmdHealthByte:                 begin valid_d = 1'b1; cmd_d = CmdHealth; end
`endif
          default:                       err_d = 1'b1;
        endcase
      end
    end else if (tmr_q == TmrLast) begin
      state_d = PsWaitSync;
      err_d   = 1'b1;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PsWaitSync;
      tmr_q     <= '0;
      cmd_valid <= 1'b0;
      cmd       <= CmdNone;
      cmd_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cmd_valid <= valid_d;
      cmd       <= cmd_d;
      cmd_error <= err_d;
    end
  end

endmodule

// File: rtl/lidar_scan_responder.sv
// LiDAR-side scan responder: answers SCAN with the descriptor, then streams 5-byte packets.
// Optional GET_HEALTH answer is enabled by defining LIDAR_HEALTH_EN.
module lidar_scan_responder
  import lidar_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W               = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       rx_data_in,
  input  logic             rx_valid_in,
  input  logic             tx_done_in,
  output logic [7:0]       tx_data_out,
  output logic             tx_start_out,
  input  logic             sample_valid_in,
  output logic             sample_ready_out,
  input  logic [14:0]      angle_in,
  input  logic [15:0]      distance_in,
  input  logic [5:0]       quality_in,
  input  logic             new_scan_in,
  output logic             scanning_out,
  output logic             cmd_error_out,
  output logic [CNT_W-1:0] packets_sent_out
);

  logic cmd_valid;
  cmd_e cmd;

  lidar_cmd_parser #(
    .SYNC_TIMEOUT_CYCLES(SYNC_TIMEOUT_CYCLES)
  ) u_parser (
    .clk      (clk_in),
    .rst      (rst_in),
    .rx_data  (rx_data_in),
    .rx_valid (rx_valid_in),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_error(cmd_error_out)
  );

  logic             start_cmd, stop_cmd, reset_cmd;
  logic [3:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [39:0]      pkt_q, pkt_d;
  logic [CNT_W-1:0] pkts_q, pkts_d;
  logic             pend_stop_q, pend_stop_d;
  logic             pend_clr_q, pend_clr_d;
  logic [39:0]      pkt_sh;

  assign start_cmd = cmd_valid && (cmd == CmdStart);
  assign reset_cmd = cmd_valid && (cmd == CmdReset);
  assign stop_cmd  = cmd_valid && ((cmd == CmdStop) || (cmd == CmdReset));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pkt_d       = pkt_q;
    pkts_d      = pkts_q;
    pend_stop_d = pend_stop_q | stop_cmd;
    pend_clr_d  = pend_clr_q | reset_cmd;
    case (state_q)
      StIdle: begin
        // A stop that lands in IDLE only has to apply its counter clear.
        if (pend_stop_q) begin
          pend_stop_d = stop_cmd;
          pend_clr_d  = reset_cmd;
          if (pend_clr_q) pkts_d = '0;
        end
        if (start_cmd) begin
          state_d = StDescLoad;
          idx_d   = '0;
        end
`ifdef LIDAR_HEALTH_EN
        else if (cmd_valid && (cmd == CmdHealth)) begin
          state_d = StHealthLoad;
          idx_d   = '0;
        end
`endif
      end
      StDescLoad: state_d = StDescWait;
      StDescWait: begin
        if (tx_done_in) begin
          if (idx_q == 4'(ScanDescLen - 1)) begin
            state_d = StSampleWait;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StDescLoad;
          end
        end
      end
      StSampleWait: begin
        if (pend_stop_q) begin
          state_d = StIdle;
        end else if (sample_valid_in) begin
          pkt_d   = {quality_in, ~new_scan_in, new_scan_in, angle_in[6:0], 1'b1,
                     angle_in[14:7], distance_in[7:0], distance_in[15:8]};
          idx_d   = '0;
          state_d = StPktLoad;
        end
      end
      StPktLoad: state_d = StPktWait;
      StPktWait: begin
        if (tx_done_in) begin
          if (idx_q == 4'(PktLen - 1)) begin
            pkts_d  = pkts_q + CNT_W'(1);
            state_d = StSampleWait;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StPktLoad;
          end
        end
      end
`ifdef LIDAR_HEALTH_EN
      StHealthLoad: state_d = StHealthWait;
      StHealthWait: begin
        if (tx_done_in) begin
          if (idx_q == 4'(HealthLen - 1)) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StHealthLoad;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      pkt_q       <= '0;
      pkts_q      <= '0;
      pend_stop_q <= 1'b0;
      pend_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pkt_q       <= pkt_d;
      pkts_q      <= pkts_d;
      pend_stop_q <= pend_stop_d;
      pend_clr_q  <= pend_clr_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them immediately.
  always_comb begin
    pkt_sh       = pkt_q << {idx_q, 3'b000};
    tx_data_out  = 8'h00;
    tx_start_out = 1'b0;
    scanning_out = 1'b0;
    case (state_q)
      StDescLoad, StDescWait: begin
        tx_data_out  = scan_desc_byte(idx_q);
        tx_start_out = (state_q == StDescLoad);
        scanning_out = 1'b1;
      end
      StPktLoad, StPktWait: begin
        tx_data_out  = pkt_sh[39:32];
        tx_start_out = (state_q == StPktLoad);
        scanning_out = 1'b1;
      end
      StSampleWait: scanning_out = 1'b1;
`ifdef LIDAR_HEALTH_EN
      StHealthLoad, StHealthWait: begin
        tx_data_out  = health_byte(idx_q);
        tx_start_out = (state_q == StHealthLoad);
      end
`endif
      default: ;
    endcase
  end

  assign sample_ready_out = (state_q == StSampleWait) && !pend_stop_q;
  assign packets_sent_out = pkts_q;

endmodule

// File: tb/tb_lidar_scan_responder.sv
// Directed bench for lidar_scan_responder with a behavioural UART-tx model (done 20 cycles
// after each start). The GET_HEALTH case follows LIDAR_HEALTH_EN.
module tb_lidar_scan_responder;

  localparam int unsigned Tmo = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [14:0] angle = '0;
  logic [15:0] distance = '0;
  logic [5:0]  quality = '0;
  logic        new_scan = 1'b0;
  logic        scanning;
  logic        cmd_error;
  logic [15:0] packets;

  lidar_scan_responder #(
    .SYNC_TIMEOUT_CYCLES(Tmo),
    .CNT_W              (16)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rx_data_in      (rx_data),
    .rx_valid_in     (rx_valid),
    .tx_done_in      (tx_done),
    .tx_data_out     (tx_data),
    .tx_start_out    (tx_start),
    .sample_valid_in (sample_valid),
    .sample_ready_out(sample_ready),
    .angle_in        (angle),
    .distance_in     (distance),
    .quality_in      (quality),
    .new_scan_in     (new_scan),
    .scanning_out    (scanning),
    .cmd_error_out   (cmd_error),
    .packets_sent_out(packets)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         err_cnt = 0;
  logic [7:0] txq[$];
  logic       uart_busy = 1'b0;

  logic [7:0] desc_exp [10] = '{8'hA5, 8'h5A, 8'h05, 8'h00, 8'h00, 8'h40, 8'h81, 0, 0, 0};
  logic [7:0] pkt1_exp [10] = '{8'hA9, 8'h69, 8'h24, 8'hCD, 8'hAB, 0, 0, 0, 0, 0};
  logic [7:0] pkt2_exp [10] = '{8'hFE, 8'h03, 8'h00, 8'h02, 8'h01, 0, 0, 0, 0, 0};
  logic [7:0] hlth_exp [10] = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00,
                                8'h00, 8'h00};

  // UART transmitter model: capture on start, finish 20 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        uart_busy = 1'b1;
        txq.push_back(tx_data);
        repeat (20) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        uart_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) if (cmd_error) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int cyc = 0;
    while (txq.size() < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1 check("tx_byte_count", txq.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (uart_busy && cyc < budget) begin
      @(posedge clk);
      #2 cyc++;
    end
    check("uart_idle", {31'd0, uart_busy}, 0);
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] e [10],
                             input int n);
    logic [31:0] got;
    for (int i = 0; i < n; i++) begin
      got = (base + i < txq.size()) ? {24'd0, txq[base+i]} : 32'h100;
      check(tag, got, {24'd0, e[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0, k;
    logic found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_ready", sample_ready, 0);
    check("rst_scanning", scanning, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_packets", packets, 0);
    rst = 1'b0;

    // SCAN -> descriptor
    send_byte(8'hA5);
    send_byte(8'h60);
    wait_bytes(1, 100);
    check("scan_first_byte", scanning, 1);
    wait_bytes(7, 400);
    check_bytes("desc", 0, desc_exp, 7);
    wait_idle(100);
    @(posedge clk);
    #1;
    check("desc_scanning", scanning, 1);
    check("desc_ready", sample_ready, 1);

    // First measurement packet
    angle = 15'h1234; distance = 16'hABCD; quality = 6'h2A; new_scan = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    wait_bytes(12, 300);
    check_bytes("pkt1", 7, pkt1_exp, 5);
    wait_idle(100);
    check("pkt1_count", packets, 1);

    // STOP mid-packet: packet completes, then idle with nothing more sent
    angle = 15'h0001; distance = 16'h0102; quality = 6'h3F; new_scan = 1'b0;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    wait_bytes(14, 200);
    send_byte(8'hA5);
    send_byte(8'h65);
    sample_valid = 1'b1;
    wait_bytes(17, 300);
    check_bytes("pkt2", 12, pkt2_exp, 5);
    wait_idle(100);
    repeat (100) @(posedge clk);
    #1;
    check("stop_no_more_tx", txq.size(), 17);
    check("stop_scanning", scanning, 0);
    check("stop_ready", sample_ready, 0);
    check("stop_count", packets, 2);
    sample_valid = 1'b0;

    // Unknown command
    e0 = err_cnt;
    base = txq.size();
    send_byte(8'hA5);
    send_byte(8'h33);
    repeat (30) @(posedge clk);
    #1;
    check("unknown_err", err_cnt - e0, 1);
    check("unknown_no_tx", txq.size(), base);

    // GET_HEALTH
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h52);
`ifdef LIDAR_HEALTH_EN
    wait_bytes(base + 10, 500);
    check_bytes("health", base, hlth_exp, 10);
    wait_idle(100);
    #1;
    check("health_no_err", err_cnt - e0, 0);
    check("health_scanning", scanning, 0);
`else
    repeat (30) @(posedge clk);
    #1;
    check("health_unknown_err", err_cnt - e0, 1);
    check("health_no_tx", txq.size(), base);
`endif

    // Sync timeout, exact cycle of the error pulse
    send_byte(8'hA5);
    k = 0;
    found = 1'b0;
    while (!found && k < 200) begin
      @(negedge clk);
      if (cmd_error) found = 1'b1;
      else k++;
    end
    check("timeout_cycles", k, Tmo);
    @(negedge clk);
    check("timeout_pulse_width", cmd_error, 0);

    // Lone command byte after resync is dropped
    e0 = err_cnt;
    base = txq.size();
    send_byte(8'h60);
    repeat (40) @(posedge clk);
    #1;
    check("lone_cmd_no_tx", txq.size(), base);
    check("lone_cmd_scanning", scanning, 0);
    check("lone_cmd_no_err", err_cnt - e0, 0);

    // A5 A5 61 starts; reset mid-descriptor clears outputs asynchronously
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h61);
    wait_bytes(base + 2, 200);
    check_bytes("force_desc", base, desc_exp, 2);
    check("force_scanning", scanning, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_tx_data", tx_data, 0);
    check("arst_tx_start", tx_start, 0);
    check("arst_scanning", scanning, 0);
    check("arst_packets", packets, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(100);

    // Restart descriptor from its first byte
    base = txq.size();
    send_byte(8'hA5);
    send_byte(8'h60);
    wait_bytes(base + 7, 400);
    check_bytes("restart_desc", base, desc_exp, 7);
    wait_idle(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
